// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Optional divide-by-zero flag port dz: define SEQ_DIVIDER_DZ_EN.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
`ifdef SEQ_DIVIDER_DZ_EN
  ,
  output logic             dz
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // After every restore/subtract the partial remainder is below the divisor,
  // so only its low WIDTH bits need storing; the shifted copy carries WIDTH+1.
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH:0]   pr_sh;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
`ifdef SEQ_DIVIDER_DZ_EN
  logic             dz_q, dz_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pr_d      = pr_q;
    dq_d      = dq_q;
    b_d       = b_q;
    q_d       = q_q;
    r_d       = r_q;
`ifdef SEQ_DIVIDER_DZ_EN
    dz_d      = dz_q;
`endif
    // Trial subtract in adder form: invert b, carry-in 1; bit WIDTH is no-borrow.
    pr_sh     = {pr_q, dq_q[WIDTH-1]};
    diff      = pr_sh + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    no_borrow = diff[WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          dq_d    = a;
          b_d     = b;
          pr_d    = '0;
          cnt_d   = '0;
`ifdef SEQ_DIVIDER_DZ_EN
          dz_d    = 1'b0;
`endif
        end
      end
      S_CALC: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d = S_DONE;
          q_d     = dq_q;
          r_d     = pr_q;
`ifdef SEQ_DIVIDER_DZ_EN
          dz_d    = (b_q == '0);
`endif
        end else begin
          pr_d  = no_borrow ? diff[WIDTH-1:0] : pr_sh[WIDTH-1:0];
          dq_d  = {dq_q[WIDTH-2:0], no_borrow};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dq_q    <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef SEQ_DIVIDER_DZ_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dq_q    <= dq_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef SEQ_DIVIDER_DZ_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
`ifdef SEQ_DIVIDER_DZ_EN
  assign dz   = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (WIDTH=4)
module tb_seq_divider;

  localparam int W = 4;

  typedef struct {
    int a;
    int b;
    int eq;
    int er;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b, q, r;
  logic         busy, done;
`ifdef SEQ_DIVIDER_DZ_EN
  logic         dz;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done)
`ifdef SEQ_DIVIDER_DZ_EN
    ,
    .dz    (dz)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_q(input int x, input int y);
    return (y == 0) ? (1 << W) - 1 : x / y;
  endfunction

  function automatic int model_r(input int x, input int y);
    return (y == 0) ? x : x % y;
  endfunction

  // Pulses start for one cycle; returns at the sampling point where done is
  // seen, with lat = edges after the accepting edge, bsy0 = busy one cycle later.
  task automatic run_div(input int ai, input int bi, output int lat, output int bsy0);
    @(negedge clk);
    a = W'(ai);
    b = W'(bi);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bsy0 = int'(busy);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[7];
  int   lat, bsy0, n, seen, ra, rb, pq, prr;

  initial begin
    vecs[0] = '{13, 4, 3, 1};
    vecs[1] = '{15, 1, 15, 0};
    vecs[2] = '{3, 7, 0, 3};
    vecs[3] = '{0, 5, 0, 0};
    vecs[4] = '{9, 0, 15, 9};
    vecs[5] = '{15, 15, 1, 0};
    vecs[6] = '{1, 15, 0, 1};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_q", int'(q), 0);
    check("reset_r", int'(r), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, lat, bsy0);
      check($sformatf("tbl%0d_latency", i), lat, W + 1);
      check($sformatf("tbl%0d_busy_after_start", i), bsy0, 1);
      check($sformatf("tbl%0d_q", i), int'(q), vecs[i].eq);
      check($sformatf("tbl%0d_r", i), int'(r), vecs[i].er);
      check($sformatf("tbl%0d_busy_at_done", i), int'(busy), 1);
`ifdef SEQ_DIVIDER_DZ_EN
      check($sformatf("tbl%0d_dz", i), int'(dz), (vecs[i].b == 0) ? 1 : 0);
`endif
      @(negedge clk);
      check($sformatf("tbl%0d_done_pulse", i), int'(done), 0);
      check($sformatf("tbl%0d_idle_busy", i), int'(busy), 0);
      check($sformatf("tbl%0d_q_held", i), int'(q), vecs[i].eq);
    end
    pq  = vecs[6].eq;
    prr = vecs[6].er;

    // start held high through CALC and DONE with different operands
    @(negedge clk);
    a = 4'd14;
    b = 4'd3;
    start = 1'b1;
    @(negedge clk);
    a = 4'd6;
    b = 4'd2;
    check("ign_old_q_during_calc", int'(q), pq);
    check("ign_old_r_during_calc", int'(r), prr);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ign_latency", n, W + 1);
    check("ign_q", int'(q), 4);
    check("ign_r", int'(r), 2);
    @(negedge clk);
    start = 1'b0;
    check("ign_no_accept_in_done", int'(busy), 0);
    @(negedge clk);
    check("ign_still_idle", int'(busy), 0);

    // reset in the middle of a division
    @(negedge clk);
    a = 4'd13;
    b = 4'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_q", int'(q), 0);
    check("rst_mid_r", int'(r), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("rst_mid_no_done", seen, 0);
    run_div(13, 4, lat, bsy0);
    check("post_rst_latency", lat, W + 1);
    check("post_rst_q", int'(q), 3);
    check("post_rst_r", int'(r), 1);

    // random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      run_div(ra, rb, lat, bsy0);
      check($sformatf("rnd a=%0d b=%0d q", ra, rb), int'(q), model_q(ra, rb));
      check($sformatf("rnd a=%0d b=%0d r", ra, rb), int'(r), model_r(ra, rb));
      check($sformatf("rnd a=%0d b=%0d lat", ra, rb), lat, W + 1);
    end

    // exhaustive, back-to-back starts in the cycle after done
    for (int ea = 0; ea < (1 << W); ea++) begin
      for (int eb = 0; eb < (1 << W); eb++) begin
        run_div(ea, eb, lat, bsy0);
        check($sformatf("exh a=%0d b=%0d q", ea, eb), int'(q), model_q(ea, eb));
        check($sformatf("exh a=%0d b=%0d r", ea, eb), int'(r), model_r(ea, eb));
        if (eb != 0) begin
          check($sformatf("exh a=%0d b=%0d identity", ea, eb), int'(q) * eb + int'(r), ea);
          check($sformatf("exh a=%0d b=%0d r_lt_b", ea, eb), (int'(r) < eb) ? 1 : 0, 1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
